// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with valid/ready handshake and a sequencer
// for the iterative multiply/divide datapath.
module alu_ctrl_seq #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_class,
    input  logic [5:0]        opcode,
    input  logic [5:0]        func,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              md_start,
    output logic              md_step,
    output logic              md_done,
    output logic              md_signed,
    output logic              md_is_div,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SLTU = 4'b0011;
    localparam logic [3:0] C_LUI  = 4'b0100;
    localparam logic [3:0] C_SLL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_XOR  = 4'b1000;
    localparam logic [3:0] C_NOR  = 4'b1001;
    localparam logic [3:0] C_SRL  = 4'b1010;
    localparam logic [3:0] C_SRA  = 4'b1011;
    localparam logic [3:0] C_MD   = 4'b1100;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q;
    logic [3:0]       alu_ctrl_q;
    logic             illegal_q;
    logic             md_signed_q;
    logic             md_is_div_q;

    logic [3:0]       dec_code;
    logic             dec_ill;
    logic             dec_md;
    logic             accept;

    // Combinational decode of class / opcode / func into a control code
    always_comb begin
        dec_code = C_ADD;
        dec_ill  = 1'b0;
        case (alu_class)
            3'b000: dec_code = C_ADD;
            3'b001: dec_code = C_SUB;
            3'b010: begin
                case (func)
                    6'b000000: dec_code = C_SLL;
                    6'b000010: dec_code = C_SRL;
                    6'b000011: dec_code = C_SRA;
                    6'b001000: dec_code = C_ADD;
                    6'b100000,
                    6'b100001: dec_code = C_ADD;
                    6'b100010,
                    6'b100011: dec_code = C_SUB;
                    6'b100100: dec_code = C_AND;
                    6'b100101: dec_code = C_OR;
                    6'b100110: dec_code = C_XOR;
                    6'b100111: dec_code = C_NOR;
                    6'b101010: dec_code = C_SLT;
                    6'b101011: dec_code = C_SLTU;
                    6'b011000,
                    6'b011001,
                    6'b011010,
                    6'b011011: dec_code = C_MD;
                    default:   dec_ill  = 1'b1;
                endcase
            end
            3'b011: begin
                case (opcode)
                    6'b001001: dec_code = C_ADD;
                    6'b001010: dec_code = C_SLT;
                    6'b001011: dec_code = C_SLTU;
                    6'b001100: dec_code = C_AND;
                    6'b001101: dec_code = C_OR;
                    6'b001110: dec_code = C_XOR;
                    6'b001111: dec_code = C_LUI;
                    default:   dec_ill  = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign dec_md   = (dec_code == C_MD);
    assign in_ready = (state_q == IDLE) & ~flush;
    assign accept   = in_valid & in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and step counter; flush aborts from any state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && dec_md) state_d = START;
                end
                START: begin
                    cnt_d   = md_is_div_q ? DIV_LOAD : MUL_LOAD;
                    state_d = RUN;
                end
                RUN: begin
                    if (cnt_q == '0) state_d = DONE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered result; MD ops carry their code until DONE presents it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_ctrl_q  <= '0;
            illegal_q   <= 1'b0;
            md_signed_q <= 1'b0;
            md_is_div_q <= 1'b0;
        end else begin
            out_valid_q <= accept & ~dec_md;
            if (accept) begin
                alu_ctrl_q <= dec_code;
                illegal_q  <= dec_ill;
                if (dec_md) begin
                    md_signed_q <= ~func[0];
                    md_is_div_q <= func[1];
                end
            end
        end
    end

    // Output decode from state; flush masks this cycle's result
    always_comb begin
        alu_ctrl       = '0;
        alu_ctrl[3:0]  = alu_ctrl_q;
        illegal        = illegal_q;
        md_signed      = md_signed_q;
        md_is_div      = md_is_div_q;
        md_start       = (state_q == START);
        md_step        = (state_q == RUN);
        md_done        = (state_q == DONE) & ~flush;
        out_valid      = (out_valid_q | (state_q == DONE)) & ~flush;
        busy           = (state_q != IDLE);
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized scoreboard bench for alu_ctrl_seq with a table-driven
// reference model and cycle-accurate expectations.
module tb_alu_ctrl_seq;

    localparam int CW  = 5;
    localparam int MUL = 4;
    localparam int DIV = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    alu_class;
    logic [5:0]    opcode;
    logic [5:0]    func;
    logic          flush;
    logic          out_valid;
    logic [CW-1:0] alu_ctrl;
    logic          illegal;
    logic          md_start;
    logic          md_step;
    logic          md_done;
    logic          md_signed;
    logic          md_is_div;
    logic          busy;

    alu_ctrl_seq #(
        .CTRL_W(CW), .MUL_CYCLES(MUL), .DIV_CYCLES(DIV), .CNT_W(6)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_class(alu_class), .opcode(opcode), .func(func),
        .flush(flush), .out_valid(out_valid), .alu_ctrl(alu_ctrl),
        .illegal(illegal), .md_start(md_start), .md_step(md_step),
        .md_done(md_done), .md_signed(md_signed),
        .md_is_div(md_is_div), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int code;
        bit ill;
        bit done;
    } exp_t;

    exp_t exq[$];
    int   rt[int];
    int   it[int];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    int   ready_at = 0, busy_lo = 0, start_at = -1;
    int   step_lo = 1, step_hi = 0, md_lo = 1, md_hi = 0;
    bit   exp_sgn = 0, exp_div = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic void refm(input int c, input int o, input int f,
                                 output int code, output bit ill);
        code = 2;
        ill  = 0;
        if (c == 0) code = 2;
        else if (c == 1) code = 6;
        else if (c == 2 && rt.exists(f)) code = rt[f];
        else if (c == 3 && it.exists(o)) code = it[o];
        else ill = 1;
    endfunction

    function automatic void model_reset();
        exq.delete();
        ready_at = 0; busy_lo = 0; start_at = -1;
        step_lo = 1; step_hi = 0; md_lo = 1; md_hi = 0;
    endfunction

    // Monitor: per-cycle control checks and scoreboard pops
    always @(negedge clk) begin
        if (mon_en) begin
            bit   bsy;
            exp_t e;
            bsy = (cyc >= busy_lo) && (cyc < ready_at);
            chk("in_ready", in_ready, !bsy && !flush);
            chk("busy", busy, bsy);
            chk("md_start", md_start, cyc == start_at);
            chk("md_step", md_step, cyc >= step_lo && cyc <= step_hi);
            if (cyc >= md_lo && cyc <= md_hi) begin
                chk("md_signed", md_signed, exp_sgn);
                chk("md_is_div", md_is_div, exp_div);
            end
            chk("md_done_alone", md_done & ~out_valid, 0);
            if (exq.size() > 0 && exq[0].cyc < cyc) begin
                chk("missing_out_valid", 0, 1);
                void'(exq.pop_front());
            end
            if (out_valid) begin
                if (exq.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = exq.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("alu_ctrl", alu_ctrl, e.code);
                    chk("illegal", illegal, e.ill);
                    chk("md_done", md_done, e.done);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    task automatic issue(input int c, input int o, input int f);
        int   n, code, t, nc;
        bit   ill, dv;
        exp_t e;
        in_valid  = 1'b1;
        alu_class = 3'(c);
        opcode    = 6'(o);
        func      = 6'(f);
        n = 0;
        while (cyc < ready_at) begin
            step();
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        t = cyc;
        refm(c, o, f, code, ill);
        if (code == 12) begin
            dv = (f == 26 || f == 27);
            nc = dv ? DIV : MUL;
            exp_sgn = (f == 24 || f == 26);
            exp_div = dv;
            busy_lo = t + 1;
            start_at = t + 1;
            step_lo = t + 2;
            step_hi = t + 1 + nc;
            md_lo = t + 1;
            md_hi = t + 2 + nc;
            ready_at = t + 3 + nc;
            e = '{cyc: t + 2 + nc, code: 12, ill: 0, done: 1};
        end else begin
            e = '{cyc: t + 1, code: code, ill: ill, done: 0};
        end
        exq.push_back(e);
        step();
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_alu_ctrl"}, alu_ctrl, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_md_start"}, md_start, 0);
        chk({tag, "_md_step"}, md_step, 0);
        chk({tag, "_md_done"}, md_done, 0);
        chk({tag, "_md_signed"}, md_signed, 0);
        chk({tag, "_md_is_div"}, md_is_div, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    int legal_f[$];
    int legal_o[$];

    initial begin
        int t, c, f, o, n;
        rt[0] = 5;  rt[2] = 10; rt[3] = 11; rt[8] = 2;
        rt[32] = 2; rt[33] = 2; rt[34] = 6; rt[35] = 6;
        rt[36] = 0; rt[37] = 1; rt[38] = 8; rt[39] = 9;
        rt[42] = 7; rt[43] = 3;
        rt[24] = 12; rt[25] = 12; rt[26] = 12; rt[27] = 12;
        it[9] = 2;  it[10] = 7; it[11] = 3; it[12] = 0;
        it[13] = 1; it[14] = 8; it[15] = 4;
        foreach (rt[k]) legal_f.push_back(k);
        foreach (it[k]) legal_o.push_back(k);

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        alu_class = '0; opcode = '0; func = '0;
        #1;
        outs_zero("reset");
        step();
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        // Back-to-back: OR, LUI, SUB
        issue(2, 0, 6'b100101);
        issue(3, 6'b001111, 0);
        issue(1, 0, 0);
        idle();

        // MULTU, then DIV with a held follow-on request
        issue(2, 0, 6'b011001);
        issue(2, 0, 6'b011010);
        issue(0, 0, 0);
        idle();

        // Illegal decodes
        issue(2, 0, 6'b111111);
        issue(3, 6'b000001, 0);
        issue(5, 0, 0);
        idle();

        // Flush on the third step of MULT
        issue(2, 0, 6'b011000);
        t = cyc - 1;
        in_valid = 1'b0;
        while (cyc < t + 4) step();
        flush = 1'b1;
        void'(exq.pop_back());
        step_hi = cyc; md_hi = cyc; ready_at = cyc + 1;
        step();
        flush = 1'b0;
        issue(2, 0, 6'b100100);
        idle();

        // Flush in DONE of MULTU
        issue(2, 0, 6'b011001);
        t = cyc - 1;
        in_valid = 1'b0;
        while (cyc < t + 2 + MUL) step();
        flush = 1'b1;
        void'(exq.pop_back());
        step();
        flush = 1'b0;
        idle();

        // Flush in IDLE kills a registered result and blocks accept
        issue(2, 0, 6'b100110);
        flush = 1'b1;
        void'(exq.pop_back());
        step();
        flush = 1'b0;
        idle();

        // Sweep legal codes
        foreach (legal_f[i]) issue(2, 0, legal_f[i]);
        foreach (legal_o[i]) issue(3, legal_o[i], 0);
        issue(0, 0, 0);
        issue(1, 0, 0);
        idle();

        // Reset in the middle of a DIV
        issue(2, 0, 6'b011010);
        t = cyc - 1;
        in_valid = 1'b0;
        while (cyc < t + 10) step();
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        outs_zero("midrun_reset");
        model_reset();
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            n = $urandom_range(0, 9);
            c = (n < 4) ? 2 : (n < 7) ? 3 : (n == 7) ? 0 :
                (n == 8) ? 1 : $urandom_range(4, 7);
            f = $urandom_range(0, 63);
            o = $urandom_range(0, 63);
            if ($urandom_range(0, 9) < 7) begin
                f = legal_f[$urandom_range(0, legal_f.size() - 1)];
                o = legal_o[$urandom_range(0, legal_o.size() - 1)];
            end
            issue(c, o, f);
            if ($urandom_range(0, 3) == 0) idle();
        end

        in_valid = 1'b0;
        n = 0;
        while ((cyc < ready_at + 2 || exq.size() > 0) && n < 200) begin
            step();
            n++;
        end
        chk("scoreboard_empty", exq.size(), 0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
